// File: rtl/axis_parallel_merger_pkg.sv
// Shared helpers for the parallel-to-serial AXI-Stream packet merger.
// Holds no bus types; it only provides index arithmetic used by the arbiter and FSM.
package axis_parallel_merger_pkg;

    localparam int unsigned MAX_CHANNELS = 16;

    // Modular add for channel indices; valid for base < n and inc <= n.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned inc,
                                             input int unsigned n);
        int unsigned s;
        s = base + inc;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/axis_parallel_merger_if.sv
// Stream interfaces: a CHANNELS-wide parallel packet bus and a single packet stream.
// ok is the per-beat handshake (valid & ready), derived once here for both sides.
interface Axis_Parallel_If #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0][DWIDTH-1:0] data;
    logic [CHANNELS-1:0]             valid;
    logic [CHANNELS-1:0]             last;
    logic [CHANNELS-1:0]             ready;
    logic [CHANNELS-1:0]             ok;

    assign ok = valid & ready;

    modport Master_Full (output data, valid, last, input ready, ok);
    modport Slave_Full  (input data, valid, last, ok, output ready);
endinterface

interface Axis_If #(
    parameter int unsigned DWIDTH = 32
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              last;
    logic              ready;
    logic              ok;

    assign ok = valid & ready;

    modport Master_Full (output data, valid, last, input ready, ok);
    modport Slave_Full  (input data, valid, last, ok, output ready);
endinterface

// File: rtl/axis_parallel_merger_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after pointer, wrapping.
module rr_arbiter
    import axis_parallel_merger_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'(wrap_add(32'(pointer), i, N));
            if (!found && request[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/axis_parallel_merger.sv
// Merges CHANNELS packetized streams onto one stream, whole packets at a time,
// with round-robin channel selection and a single full-throughput output register.
module axis_parallel_merger
    import axis_parallel_merger_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    Axis_Parallel_If.Slave_Full data_in,
    Axis_If.Master_Full         data_out,
    output logic [IW-1:0]       chan_id
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       gnt_q, gnt_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [CHANNELS-1:0] arb_grant;
    logic [IW-1:0]       arb_index;
    logic [IW-1:0]       sel;
    logic                active;
    logic                out_free;
    logic                accept;
    logic                accept_last;

    logic [DWIDTH-1:0]   data_q;
    logic                valid_q;
    logic                last_q;
    logic [IW-1:0]       chan_q;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .request (data_in.valid),
        .pointer (ptr_q),
        .grant   (arb_grant),
        .index   (arb_index)
    );

    // In IDLE the arbiter picks live, so the winner's first beat goes through this cycle.
    assign sel         = (state_q == LOCKED) ? gnt_q : arb_index;
    assign active      = (state_q == LOCKED) || (|arb_grant);
    assign out_free    = !valid_q || data_out.ready;
    assign accept      = data_in.ok[sel];
    assign accept_last = accept && data_in.last[sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Lock onto the chosen channel until its last beat; pointer moves past it on release.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (active) begin
                    if (accept_last) begin
                        ptr_d = IW'(wrap_add(32'(sel), 32'd1, CHANNELS));
                    end else begin
                        state_d = LOCKED;
                        gnt_d   = sel;
                    end
                end
            end
            LOCKED: begin
                if (accept_last) begin
                    state_d = IDLE;
                    ptr_d   = IW'(wrap_add(32'(gnt_q), 32'd1, CHANNELS));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the selected channel ever sees ready, and never while reset is held.
    always_comb begin
        data_in.ready = '0;
        if (active && out_free && !reset) begin
            data_in.ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            last_q  <= data_in.last[sel];
            data_q  <= data_in.data[sel];
            chan_q  <= sel;
        end else if (data_out.ok) begin
            valid_q <= 1'b0;
        end
    end

    assign data_out.valid = valid_q;
    assign data_out.last  = last_q;
    assign data_out.data  = data_q;
    assign chan_id        = chan_q;

endmodule

// File: tb/tb_axis_parallel_merger.sv
// Directed and randomized-backpressure bench for axis_parallel_merger with a
// per-channel packet scoreboard and cycle-by-cycle output protocol checks.
module tb_axis_parallel_merger;

    localparam int unsigned DW = 32;
    localparam int unsigned CH = 4;
    localparam int TIMEOUT = 2000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [7:0]    ch;
        logic [DW-1:0] data;
        logic          last;
        logic [31:0]   cyc;
    } cap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] chan_id;

    Axis_Parallel_If #(.DWIDTH(DW), .CHANNELS(CH)) data_in ();
    Axis_If #(.DWIDTH(DW)) data_out ();

    axis_parallel_merger #(.DWIDTH(DW), .CHANNELS(CH)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .chan_id  (chan_id)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] drv_data  [CH];
    logic          drv_valid [CH];
    logic          drv_last  [CH];
    logic          out_ready;
    logic          rand_ready;

    always_comb begin
        for (int c = 0; c < int'(CH); c++) begin
            data_in.data[c]  = drv_data[c];
            data_in.valid[c] = drv_valid[c];
            data_in.last[c]  = drv_last[c];
        end
        data_out.ready = out_ready;
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    int n_tests = 0;
    int n_fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: beats accepted per channel, in order; plus a log of output beats.
    beat_t sb_q [CH][$];
    cap_t  cap[$];
    int    out_cnt [CH];
    int    sent    [CH];
    int    pkts    = 0;
    int    cyc     = 0;

    always @(posedge clk) cyc++;

    function automatic int sb_total();
        int t = 0;
        for (int c = 0; c < int'(CH); c++) t += sb_q[c].size();
        return t;
    endfunction

    logic       lat_pend   = 1'b0;
    beat_t      lat_beat;
    logic [1:0] lat_ch;
    logic       stall_prev = 1'b0;
    beat_t      stall_beat;
    logic [1:0] stall_ch;
    int         open_ch    = -1;

    always @(negedge clk) begin
        int    ch;
        beat_t e;
        cap_t  ce;
        if (reset) begin
            for (int c = 0; c < int'(CH); c++) sb_q[c].delete();
            lat_pend   = 1'b0;
            stall_prev = 1'b0;
            open_ch    = -1;
        end else begin
            check("ready_onehot", 64'($countones(data_in.ready) <= 1), 64'd1);
            if (lat_pend) begin
                check("lat_valid", 64'(data_out.valid), 64'd1);
                check("lat_data",  64'(data_out.data),  64'(lat_beat.data));
                check("lat_last",  64'(data_out.last),  64'(lat_beat.last));
                check("lat_chan",  64'(chan_id),        64'(lat_ch));
            end
            if (stall_prev) begin
                check("hold_valid", 64'(data_out.valid), 64'd1);
                check("hold_data",  64'(data_out.data),  64'(stall_beat.data));
                check("hold_last",  64'(data_out.last),  64'(stall_beat.last));
                check("hold_chan",  64'(chan_id),        64'(stall_ch));
            end
            if (data_out.valid && data_out.ready) begin
                ch = int'(chan_id);
                if (open_ch >= 0) check("no_interleave", 64'(chan_id), 64'(open_ch));
                open_ch = data_out.last ? -1 : ch;
                check("sb_nonempty", 64'(sb_q[ch].size() != 0), 64'd1);
                if (sb_q[ch].size() != 0) begin
                    e = sb_q[ch].pop_front();
                    check("sb_data", 64'(data_out.data), 64'(e.data));
                    check("sb_last", 64'(data_out.last), 64'(e.last));
                end
                out_cnt[ch]++;
                ce.ch   = 8'(chan_id);
                ce.data = data_out.data;
                ce.last = data_out.last;
                ce.cyc  = 32'(cyc);
                cap.push_back(ce);
            end
            stall_prev      = data_out.valid && !data_out.ready;
            stall_beat.data = data_out.data;
            stall_beat.last = data_out.last;
            stall_ch        = chan_id;
            lat_pend = 1'b0;
            for (int c = 0; c < int'(CH); c++) begin
                if (drv_valid[c] && data_in.ready[c]) begin
                    e.data = drv_data[c];
                    e.last = drv_last[c];
                    sb_q[c].push_back(e);
                    lat_pend = 1'b1;
                    lat_beat = e;
                    lat_ch   = 2'(c);
                end
            end
        end
    end

    // Called and returns at posedge+1; samples the handshake at the preceding negedge.
    task automatic wait_hs(input int ch, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < TIMEOUT && !ok; n++) begin
            @(negedge clk);
            ok = drv_valid[ch] && data_in.ready[ch];
            @(posedge clk);
            #1;
        end
        if (!ok) check($sformatf("hs_timeout_ch%0d", ch), 64'(ok), 64'd1);
    endtask

    task automatic send_packet(input int ch, input logic [DW-1:0] base,
                               input int len, input int n_send);
        bit ok;
        for (int k = 0; k < n_send; k++) begin
            drv_data[ch]  = base + DW'(k);
            drv_last[ch]  = (k == len - 1);
            drv_valid[ch] = 1'b1;
            wait_hs(ch, ok);
            if (!ok) begin
                drv_valid[ch] = 1'b0;
                return;
            end
        end
        if (n_send == len) drv_valid[ch] = 1'b0;
    endtask

    task automatic run_random(input int ch);
        int gap;
        int len;
        for (int p = 0; p < 25; p++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            len = $urandom_range(1, 4);
            send_packet(ch, 32'((ch << 16) | (p << 4)), len, len);
            sent[ch] += len;
            pkts++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int c = 0; c < int'(CH); c++) drv_valid[c] = 1'b0;
        #1;
        check("rst_out_valid", 64'(data_out.valid), 64'd0);
        check("rst_ready",     64'(data_in.ready),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < int'(CH); c++) begin
            out_cnt[c] = 0;
            sent[c]    = 0;
        end
        out_ready = 1'b1;
        reset     = 1'b0;
        cap.delete();
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_total() != 0 || data_out.valid) && n < TIMEOUT) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_done", 64'(n < TIMEOUT), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int ech;
        out_ready  = 1'b1;
        rand_ready = 1'b0;
        for (int c = 0; c < int'(CH); c++) begin
            drv_valid[c] = 1'b0;
            drv_last[c]  = 1'b0;
            drv_data[c]  = '0;
            out_cnt[c]   = 0;
            sent[c]      = 0;
        end
        reset = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        check("init_valid", 64'(data_out.valid), 64'd0);
        check("init_last",  64'(data_out.last),  64'd0);
        check("init_chan",  64'(chan_id),        64'd0);
        check("init_data",  64'(data_out.data),  64'd0);
        check("init_ready", 64'(data_in.ready),  64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single channel, five-beat packet on ch2.
        do_reset();
        send_packet(2, 32'h10, 5, 5);
        drain();
        check("t1_count", 64'(cap.size()), 64'd5);
        for (int i = 0; i < 5 && i < cap.size(); i++) begin
            check($sformatf("t1_ch[%0d]", i),   64'(cap[i].ch),   64'd2);
            check($sformatf("t1_data[%0d]", i), 64'(cap[i].data), 64'(32'h10 + i));
            check($sformatf("t1_last[%0d]", i), 64'(cap[i].last), 64'(i == 4));
            check($sformatf("t1_cyc[%0d]", i),  64'(cap[i].cyc),  64'(cap[0].cyc + 32'(i)));
        end

        // All four channels start three-beat packets together.
        do_reset();
        fork
            send_packet(0, 32'h000, 3, 3);
            send_packet(1, 32'h100, 3, 3);
            send_packet(2, 32'h200, 3, 3);
            send_packet(3, 32'h300, 3, 3);
        join
        drain();
        check("t2_count", 64'(cap.size()), 64'd12);
        for (int i = 0; i < 12 && i < cap.size(); i++) begin
            ech = i / 3;
            check($sformatf("t2_ch[%0d]", i),   64'(cap[i].ch),   64'(ech));
            check($sformatf("t2_data[%0d]", i), 64'(cap[i].data), 64'((ech << 8) | (i % 3)));
            check($sformatf("t2_last[%0d]", i), 64'(cap[i].last), 64'((i % 3) == 2));
            check($sformatf("t2_cyc[%0d]", i),  64'(cap[i].cyc),  64'(cap[0].cyc + 32'(i)));
        end

        // Continuous single-beat packets on ch1 and ch3.
        do_reset();
        fork
            begin
                for (int k = 0; k < 6; k++) send_packet(1, 32'h1000 + 32'(k), 1, 1);
            end
            begin
                for (int j = 0; j < 6; j++) send_packet(3, 32'h3000 + 32'(j), 1, 1);
            end
        join
        drain();
        check("t3_count", 64'(cap.size()), 64'd12);
        for (int i = 0; i < 12 && i < cap.size(); i++) begin
            ech = (i % 2 == 0) ? 1 : 3;
            check($sformatf("t3_ch[%0d]", i),   64'(cap[i].ch),   64'(ech));
            check($sformatf("t3_data[%0d]", i), 64'(cap[i].data), 64'((ech << 12) + i / 2));
            check($sformatf("t3_last[%0d]", i), 64'(cap[i].last), 64'd1);
        end

        // Random arrivals on all channels against random output backpressure.
        do_reset();
        pkts       = 0;
        rand_ready = 1'b1;
        fork
            run_random(0);
            run_random(1);
            run_random(2);
            run_random(3);
        join
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();
        check("t4_packets", 64'(pkts), 64'd100);
        for (int c = 0; c < int'(CH); c++) begin
            check($sformatf("t4_beats_ch%0d", c), 64'(out_cnt[c]), 64'(sent[c]));
        end
        check("t4_sb_empty", 64'(sb_total()), 64'd0);

        // Reset in the middle of a six-beat ch0 packet, then a clean ch3 packet.
        do_reset();
        send_packet(0, 32'h50, 6, 2);
        check("t5_held_valid", 64'(data_out.valid), 64'd1);
        check("t5_held_data",  64'(data_out.data),  64'h51);
        #2 reset = 1'b1;
        #1;
        check("t5_async_valid", 64'(data_out.valid), 64'd0);
        check("t5_async_last",  64'(data_out.last),  64'd0);
        check("t5_async_chan",  64'(chan_id),        64'd0);
        check("t5_async_ready", 64'(data_in.ready),  64'd0);
        for (int c = 0; c < int'(CH); c++) drv_valid[c] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cap.delete();
        send_packet(3, 32'hA0, 3, 3);
        drain();
        check("t5_count", 64'(cap.size()), 64'd3);
        for (int i = 0; i < 3 && i < cap.size(); i++) begin
            check($sformatf("t5_ch[%0d]", i),   64'(cap[i].ch),   64'd3);
            check($sformatf("t5_data[%0d]", i), 64'(cap[i].data), 64'(32'hA0 + i));
            check($sformatf("t5_last[%0d]", i), 64'(cap[i].last), 64'(i == 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/axis_parallel_merger.md
AXIS_PARALLEL_MERGER -- requirements
Module: axis_parallel_merger

Interface
REQ-001 SHALL have parameter DWIDTH, default 32: sample width per channel.
REQ-002 SHALL have parameter CHANNELS, default 4: number of parallel input channels; legal values are 1..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data_in, Axis_Parallel_If.Slave_Full, CHANNELS x DWIDTH: the packetized parallel input, with per-channel ready/valid/last.
REQ-006 SHALL have port data_out, Axis_If.Master_Full, DWIDTH: the merged packetized output stream.
REQ-007 SHALL have port chan_id, output, $clog2(CHANNELS) bits (min 1): source channel of the current data_out beat; valid whenever data_out.valid is high.

Function
REQ-008 SHALL forward whole packets from data_in channels onto data_out without interleaving beats of different packets.
REQ-009 SHALL run a two-state FSM: IDLE (no grant) and LOCKED (grant held on channel g).
REQ-010 In IDLE, SHALL grant the first channel with valid high, searching round-robin from (last granted + 1) mod CHANNELS; search start is 0 after reset.
REQ-011 Grant decision SHALL be combinational in IDLE, so the granted channel's first beat is accepted in the same cycle; no idle bubble.
REQ-012 In LOCKED, only data_in.ready[g] SHALL be asserted; all other ready bits SHALL be 0.
REQ-013 data_in.ready[g] SHALL be high when data_out.valid is 0 or data_out.ready is 1 (single register stage; full throughput).
REQ-014 On data_in.ok[g], SHALL register data, last and g into data_out.data, data_out.last and chan_id, and set data_out.valid; latency is 1 cycle.
REQ-015 data_out.valid SHALL clear when data_out.ok occurs and no new beat is accepted in that cycle.
REQ-016 data_out data/last/chan_id SHALL hold stable while valid is high and ready is low.
REQ-017 An accepted beat with last=1 SHALL return the FSM to IDLE next cycle and record g as last granted.
REQ-018 A single-beat packet (valid and last in the grant cycle) SHALL be accepted and return to IDLE; the next grant may be issued the following cycle.
REQ-019 When several channels request simultaneously, SHALL serve each in round-robin order; no requesting channel waits more than CHANNELS-1 packets.
REQ-020 A packet with no last SHALL hold the grant indefinitely; this is documented behaviour, with no timeout.
REQ-021 With CHANNELS=1, SHALL degrade to a one-stage register slice; chan_id is held at 0.
REQ-022 SHALL NOT drive ready[i] in IDLE for any channel other than the one being granted that cycle.

Reset
REQ-023 On reset, SHALL asynchronously set FSM=IDLE, round-robin pointer=0, data_out.valid=0, data_out.last=0, chan_id=0 and all data_in.ready=0.
REQ-024 Reset mid-packet SHALL discard the partial packet and any held output beat; the next grant after reset starts a fresh search from channel 0.
REQ-025 data_out.data reset value is don't-care but SHALL be reset to 0 for simulation determinism.

Structure
REQ-026 SHALL need no new package types; the chan_id width localparam is computed in the module.
REQ-027 SHALL instantiate one sub-module, rr_arbiter (parameter N; inputs request[N] and pointer; outputs one-hot grant and index); the FSM and output register stay in axis_parallel_merger.

Verification
REQ-028 Verify single channel: channel 2 sends 5 beats 0x10..0x14 with last on the 5th, data_out.ready=1 -> out beats 0x10..0x14 one cycle later, chan_id=2, last only on 0x14.
REQ-029 Verify simultaneous requests: all 4 channels start 3-beat packets in the same cycle -> output order ch0, ch1, ch2, ch3, 12 beats back-to-back with no bubbles.
REQ-030 Verify backpressure: data_out.ready toggled randomly 50%, with send_samples random arrivals on all channels, 100 packets -> per-channel scoreboard matches, no beat dropped or duplicated, and output stable while stalled.
REQ-031 Verify single-beat packets: ch1 and ch3 send 1-beat packets continuously -> output alternates ch1, ch3, and each beat has last=1.
REQ-032 Verify reset mid-packet: reset asserted after beat 2 of a 6-beat ch0 packet -> data_out.valid=0 immediately (asynchronous), and after release ch3 alone requesting is granted and forwarded cleanly.
